// File: rtl/gate_tt_pkg.sv
// Shared types and truth tables for the two-input gate truth-table exerciser.
// Tables are indexed by {a,b}: bit 0 = a0b0 ... bit 3 = a1b1.
package gate_tt_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned VEC_N = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_t;

  localparam logic [VEC_N-1:0] TT_AND  = 4'b1000;
  localparam logic [VEC_N-1:0] TT_OR   = 4'b1110;
  localparam logic [VEC_N-1:0] TT_NAND = 4'b0111;
  localparam logic [VEC_N-1:0] TT_NOR  = 4'b0001;
  localparam logic [VEC_N-1:0] TT_XOR  = 4'b0110;
  localparam logic [VEC_N-1:0] TT_XNOR = 4'b1001;

  // True when the observed gate output disagrees with the table entry for idx.
  function automatic logic tt_miss(input logic [VEC_N-1:0] tt,
                                   input logic [IDX_W-1:0] idx,
                                   input logic             out);
    return out != tt[idx];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags when the settle interval has elapsed.
// zero is registered alongside the count so consumers see a flop output.
module settle_timer
  import gate_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      zero <= (load_val == '0);
    end else if (!zero) begin
      cnt  <= cnt - CNT_W'(1);
      zero <= (cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Drives a two-input gate through 00,01,10,11, samples its output after a
// settle interval and reports a per-vector fail mask plus an overall pass flag.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter logic [VEC_N-1:0] EXPECTED = TT_NOR,
  parameter int unsigned      SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gate_out,
  output logic             a,
  output logic             b,
  output logic [IDX_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [VEC_N-1:0] fail_mask
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(VEC_N - 1);

  tt_state_t        state;
  logic [IDX_W-1:0] idx;
  logic             timer_zero;
  logic             load_c;
  logic [VEC_N-1:0] mask_upd_c;

  assign vec_idx = {a, b};
  assign load_c  = (state == ST_DRIVE);

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  // Fail mask as it will stand after the current vector is sampled.
  always_comb begin
    mask_upd_c = fail_mask;
    if (tt_miss(EXPECTED, idx, gate_out)) mask_upd_c[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            state     <= ST_DRIVE;
            idx       <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_DRIVE: begin
          a     <= idx[1];
          b     <= idx[0];
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_zero) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          fail_mask <= mask_upd_c;
          if (idx == IDX_LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (mask_upd_c == '0);
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          // a/b stay on the last vector through DONE and drop on the way out.
          state <= ST_IDLE;
          busy  <= 1'b0;
          a     <= 1'b0;
          b     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Self-checking bench for gate_tt_checker: table-driven gate behaviours,
// randomized gates against a timing/result model, and reset/start corner cases.
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic       gate_out, gate_out2;
  logic       a, b, busy, done, pass;
  logic [1:0] vec_idx;
  logic [3:0] fail_mask;
  logic       a2, b2, busy2, done2, pass2;
  logic [1:0] vec_idx2;
  logic [3:0] fail_mask2;
  logic [3:0] gtab;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate under test for the default instance is any 2-input function from a table.
  always_comb gate_out  = gtab[{a, b}];
  always_comb gate_out2 = ~(a2 | b2);

  gate_tt_checker dut (
    .clk(clk), .rst(rst), .start(start), .gate_out(gate_out),
    .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask)
  );

  gate_tt_checker #(.EXPECTED(TT_AND), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_out(gate_out2),
    .a(a2), .b(b2), .vec_idx(vec_idx2), .busy(busy2), .done(done2),
    .pass(pass2), .fail_mask(fail_mask2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " a"}, int'(a), 0);
    chk({tag, " b"}, int'(b), 0);
    chk({tag, " vec_idx"}, int'(vec_idx), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " pass"}, int'(pass), 0);
    chk({tag, " fail_mask"}, int'(fail_mask), 0);
  endtask

  // One full run: start accepted at edge 0; after edge k the model expects
  // vector (k-1)/P driven, k/P vectors sampled and done exactly at edge 4P.
  task automatic run(input int sel, input logic [3:0] g, input logic [3:0] exp_mask,
                     input logic exp_pass, input int period, input bit noise);
    int last, samples, exp_ab, exp_partial;
    int ab, vi, bz, dn, ps, fm;
    last = 4 * period;
    gtab = g;
    @(negedge clk);
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    for (int k = 1; k <= last + 4; k++) begin
      if (noise && (k == 3 || k == last)) begin
        if (sel == 0) start = 1'b1; else start2 = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; start2 = 1'b0;
      if (sel == 0) begin
        ab = int'({a, b}); vi = int'(vec_idx); bz = int'(busy);
        dn = int'(done); ps = int'(pass); fm = int'(fail_mask);
      end else begin
        ab = int'({a2, b2}); vi = int'(vec_idx2); bz = int'(busy2);
        dn = int'(done2); ps = int'(pass2); fm = int'(fail_mask2);
      end
      exp_ab      = (k <= last) ? (k - 1) / period : 0;
      samples     = (k / period > 4) ? 4 : k / period;
      exp_partial = int'(exp_mask) & ((1 << samples) - 1);
      chk("ab", ab, exp_ab);
      chk("vec_idx", vi, exp_ab);
      chk("busy", bz, (k <= last) ? 1 : 0);
      chk("done", dn, (k == last) ? 1 : 0);
      chk("fail_mask", fm, exp_partial);
      chk("pass", ps, (k >= last) ? int'(exp_pass) : 0);
    end
  endtask

  typedef struct {
    logic [3:0] gtab;
    logic [3:0] mask;
    logic       pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; gtab = TT_NOR;
    tbl[0] = '{TT_NOR,  4'b0000, 1'b1};
    tbl[1] = '{4'b0000, 4'b0001, 1'b0};
    tbl[2] = '{4'b1111, 4'b1110, 1'b0};
    tbl[3] = '{4'b0101, 4'b0100, 1'b0};
    tbl[4] = '{TT_NOR,  4'b0000, 1'b1};
    tbl[5] = '{TT_XOR,  4'b0111, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset_vals("in reset");
    chk("dut2 busy in reset", int'(busy2), 0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("after reset");

    // Table-driven gate behaviours; entries 3->4 give fail-then-pass back to back.
    for (int i = 0; i < 6; i++) run(0, tbl[i].gtab, tbl[i].mask, tbl[i].pass, 4, 1'b0);

    // NOR gate checked against an AND table with a one-cycle settle.
    run(1, 4'b0000, 4'b1001, 1'b0, 3, 1'b0);

    // start pulses at edge 3 and in the DONE cycle are ignored.
    run(0, TT_NOR, 4'b0000, 1'b1, 4, 1'b1);
    run(0, 4'b1111, 4'b1110, 1'b0, 4, 1'b1);

    // Asynchronous reset mid-run aborts without a done.
    gtab = 4'b0000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre-reset busy", int'(busy), 1);
    chk("pre-reset fail_mask", int'(fail_mask), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("no done after abort", int'(done), 0);
      chk("idle after abort", int'(busy), 0);
    end
    run(0, TT_NOR, 4'b0000, 1'b1, 4, 1'b0);

    // Random gate functions against the model result gate ^ expected table.
    for (int i = 0; i < 16; i++) begin
      g = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(0, g, g ^ TT_NOR, (g == TT_NOR), 4, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
